// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for a soft CPU: debounced front-panel buttons,
// a timed CPU reset hold after power-up, and a prescaled CPU clock enable.
module cpu_run_ctrl #(
    parameter int DEB_CYCLES  = 16,
    parameter int PRESCALE    = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       nRUN,
    input  logic       nSTEP,
    output logic       CPU_CE,
    output logic       CPU_nRESET,
    output logic       RUNNING,
    output logic [7:0] CE_CNT
);

    // States: HOLD cpu held in reset | HALT stopped | STEP single CE | RUN prescaled CE
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(PRESCALE + 1);

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_NEAR  = DW'(DEB_CYCLES - 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    sync_prev;
    logic [1:0]    level;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          ce_next;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] prescale_cnt;

    // Level is accepted on the same edge the stability counter reaches its top value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            sync_prev  <= 2'b11;
            level      <= 2'b11;
            press      <= 2'b00;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1     <= {nSTEP, nRUN};
            sync2     <= sync1;
            sync_prev <= sync2;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != sync_prev[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    if (deb_cnt[i] != DEB_MAX) begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                    if (deb_cnt[i] >= DEB_NEAR) begin
                        level[i] <= sync2[i];
                        press[i] <= level[i] & ~sync2[i];
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        ce_next    = 1'b0;
        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (press[0]) begin
                    state_next = S_RUN;
                end else if (press[1]) begin
                    state_next = S_STEP;
                    ce_next    = 1'b1;
                end
            end
            S_STEP: begin
                state_next = S_HALT;
            end
            S_RUN: begin
                // A stop request suppresses the enable even on a prescaler terminal count.
                if (press[0]) begin
                    state_next = S_HALT;
                end else begin
                    ce_next = (prescale_cnt == PRE_LAST);
                end
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            prescale_cnt <= '0;
            CPU_CE       <= 1'b0;
            CPU_nRESET   <= 1'b0;
            RUNNING      <= 1'b0;
            CE_CNT       <= '0;
        end else begin
            state      <= state_next;
            CPU_CE     <= ce_next;
            CPU_nRESET <= (state_next != S_HOLD);
            RUNNING    <= (state_next == S_RUN);
            if (ce_next) begin
                CE_CNT <= CE_CNT + 8'd1;
            end
            if (state == S_HOLD && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state != S_RUN || prescale_cnt == PRE_LAST) begin
                prescale_cnt <= '0;
            end else begin
                prescale_cnt <= prescale_cnt + 1'b1;
            end
        end
    end

endmodule
